// File: rtl/s_spi_reg_bank_if.sv
// Link between the SPI slave front end and the register-bank back end.
//   SS     : slave select straight from the pins, idle high, asynchronous to clk
//   i_data : word the slave latched at the end of the last frame (changes only at SS rising)
//   o_data : response word presented to the slave's transmit input for the next frame
// Modports:
//   master : the SPI slave side (drives SS and i_data, consumes o_data)
//   slave  : the register bank (consumes SS and i_data, drives o_data)
interface s_spi_reg_bank_if;
   logic        SS;
   logic [31:0] i_data;
   logic [31:0] o_data;

   modport master (output SS, output i_data, input  o_data);
   modport slave  (input  SS, input  i_data, output o_data);
endinterface

// File: rtl/s_spi_reg_bank.sv
// Register-bank back end for the SPI slave.
// Takes the 32-bit word received in each frame, decodes it as a read or write
// of one of eight 16-bit registers, executes it and loads a 32-bit response
// word for the next frame.
//
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   bus          : s_spi_reg_bank_if.slave (SS, i_data in; o_data out)
//   i_status     : live status word, read as register 1 (clk-synchronous)
//   o_ctrl       : contents of register 2
//   o_wr_strobe  : one-cycle pulse for each accepted write
//   o_frame_done : one-cycle pulse when a response word is loaded
//
// Command word:  [31] write, [30:24] address, [23:16] ignored, [15:0] write data
// Response word: [31:24] frame count, [23] err, [22] overrun, [21:20] 0,
//                [19:16] addr[3:0], [15:0] read/write data
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for SS rising (frame end) seen through the synchroniser
// CAPTURE | i_data is settled; copy it into the command register
// EXEC    | decode, perform the register write or read, build rdata/err
// LOAD    | publish the response if SS is still high, else flag overrun
module s_spi_reg_bank #(
   parameter logic [15:0] DEVICE_ID = 16'h5A01,
   parameter int          NUM_REGS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   s_spi_reg_bank_if.slave       bus,
   input  logic [15:0]           i_status,
   output logic [15:0]           o_ctrl,
   output logic                  o_wr_strobe,
   output logic                  o_frame_done
);

   typedef enum logic [1:0] {IDLE, CAPTURE, EXEC, LOAD} state_t;

   state_t      r_state;
   logic        r_ss_s1;
   logic        r_ss_s2;
   logic        r_ss_d;
   logic [31:0] r_cmd;
   logic        r_err;
   logic        r_overrun;
   logic [15:0] r_rdata;
   logic [7:0]  r_frame_cnt;
   logic [31:0] r_o_data;
   logic        r_wr_strobe;
   logic        r_frame_done;
   logic [15:0] r_regs [NUM_REGS];

   logic        w_frame_end;
   logic        w_cmd_wr;
   logic [6:0]  w_cmd_addr;
   logic [15:0] w_cmd_wdata;
   logic        w_err;
   logic [15:0] w_rd_mux;
   logic [31:0] w_resp;
   logic        w_unused_cmd;

   assign w_frame_end  = r_ss_s2 & ~r_ss_d;
   assign w_cmd_wr     = r_cmd[31];
   assign w_cmd_addr   = r_cmd[30:24];
   assign w_cmd_wdata  = r_cmd[15:0];
   assign w_unused_cmd = ^r_cmd[23:16];

   // Registers 0 and 1 are read-only; anything past the last register is rejected.
   assign w_err = (w_cmd_addr > 7'(NUM_REGS - 1)) || (w_cmd_wr && (w_cmd_addr < 7'd2));

   always_comb begin
      w_rd_mux = r_regs[w_cmd_addr[2:0]];
      if (w_cmd_addr[2:0] == 3'd0) w_rd_mux = DEVICE_ID;
      if (w_cmd_addr[2:0] == 3'd1) w_rd_mux = i_status;
   end

   assign w_resp = {r_frame_cnt, r_err, r_overrun, 2'b00, w_cmd_addr[3:0], r_rdata};

   assign bus.o_data   = r_o_data;
   assign o_ctrl       = r_regs[2];
   assign o_wr_strobe  = r_wr_strobe;
   assign o_frame_done = r_frame_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchroniser resets high so SS held low across reset release
         // cannot look like a frame end.
         r_ss_s1      <= 1'b1;
         r_ss_s2      <= 1'b1;
         r_ss_d       <= 1'b1;
         r_state      <= IDLE;
         r_cmd        <= '0;
         r_err        <= 1'b0;
         r_overrun    <= 1'b0;
         r_rdata      <= '0;
         r_frame_cnt  <= '0;
         r_o_data     <= '0;
         r_wr_strobe  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_ss_s1      <= bus.SS;
         r_ss_s2      <= r_ss_s1;
         r_ss_d       <= r_ss_s2;
         r_wr_strobe  <= 1'b0;
         r_frame_done <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_frame_end) r_state <= CAPTURE;
            end
            CAPTURE: begin
               // i_data has been quiet for at least two clocks by now.
               r_cmd   <= bus.i_data;
               r_state <= EXEC;
            end
            EXEC: begin
               r_err <= w_err;
               if (w_err) begin
                  r_rdata <= '0;
               end else if (w_cmd_wr) begin
                  r_regs[w_cmd_addr[2:0]] <= w_cmd_wdata;
                  r_wr_strobe             <= 1'b1;
                  r_rdata                 <= w_cmd_wdata;
               end else begin
                  r_rdata <= w_rd_mux;
               end
               r_state <= LOAD;
            end
            LOAD: begin
               // Only touch o_data while SS is high; if the next frame has
               // already begun the response is dropped and reported later.
               if (r_ss_s2) begin
                  r_o_data     <= w_resp;
                  r_frame_done <= 1'b1;
                  r_frame_cnt  <= r_frame_cnt + 8'd1;
                  r_overrun    <= 1'b0;
               end else begin
                  r_overrun    <= 1'b1;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/s_spi_reg_bank.md
# s_spi_reg_bank

Register-bank back end for the SPI slave. It consumes each 32-bit word the slave latches at the end of a frame, decodes it as a read or write command, and executes it against eight 16-bit registers. It then loads a 32-bit response word onto the slave's transmit input for the next frame. It sits directly downstream of the SPI slave, with SS and the received word both crossing from the SCLK domain into the system clock domain.

## Interface
Parameters:
- DEVICE_ID, 16'h5A01, read-only contents of register 0
- NUM_REGS, 8, register count; fixed at 8, the address check is hard-wired to it

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- SS  input  1  slave select from the SPI pins; asynchronous to clk; idle high
- i_data  input  32  word received by the slave, latched at SS rising; asynchronous to clk
- o_data  output  32  response word driven to the slave's transmit input
- i_status  input  16  live status, readable as register 1
- o_ctrl  output  16  register 2 contents
- o_wr_strobe  output  1  one-cycle pulse on each accepted write
- o_frame_done  output  1  one-cycle pulse when a response is loaded

## Operation
Command word format:
- [31] is the write flag.
- [30:24] is the address.
- [23:16] is ignored.
- [15:0] is write data.

Register map:
- 0: DEVICE_ID, read-only.
- 1: i_status, read-only.
- 2–7: read/write. Register 2 also drives o_ctrl.

Synchronisation and frame detection:
- SS passes through a 2-flop synchroniser, ss_s1 then ss_s2, plus a delay flop ss_d.
- All three flops reset to 1, so no edge is detected at reset release.
- A frame end is detected when ss_s2 = 1 and ss_d = 0.

State machine (IDLE, CAPTURE, EXEC, LOAD):
- IDLE: on frame end, go to CAPTURE.
- CAPTURE: cmd <= i_data, then go to EXEC. i_data has been stable for at least 2 clk cycles at this point, and the slave only changes it at SS rising.
- EXEC: decode the command and go to LOAD.
  - err = 1 if addr > 7, or if it is a write to register 0 or 1.
  - Valid write: reg[addr] <= data, o_wr_strobe = 1, rdata = data.
  - Valid read: rdata = reg[addr].
  - Error: no register changes and rdata = 0.
- LOAD, with ss_s2 = 1:
  - o_data <= resp.
  - o_frame_done = 1.
  - frame_cnt increments, wrapping 255 -> 0.
  - overrun is cleared.
  - Go to IDLE.
- LOAD, with ss_s2 = 0 (the next frame has already started):
  - o_data is unchanged.
  - overrun <= 1.
  - No frame_done pulse and no frame_cnt increment.
  - Go to IDLE.
  - Register writes already done in EXEC stand.

Response word layout:
- [31:24]: frame_cnt value before the increment.
- [23]: err.
- [22]: overrun, i.e. a previous response was dropped.
- [21:20]: 0.
- [19:16]: addr[3:0].
- [15:0]: rdata.

Other rules:
- o_data changes only while ss_s2 = 1, so it never changes mid-frame.
- A frame end that arrives while the FSM is not in IDLE is ignored.

## Timing
Reset values:
- o_data = 0, o_ctrl = 0, o_wr_strobe = 0, o_frame_done = 0.
- Registers 2–7 = 0, frame_cnt = 0, overrun = 0, state = IDLE.

Latency:
- SS rising to ss_s2 high: 2–3 clk cycles.
- Detect cycle N (IDLE -> CAPTURE): CAPTURE at N+1, EXEC at N+2 (o_wr_strobe high), LOAD at N+3 (o_data and o_frame_done update).
- From SS rising to o_data valid: at most 6 clk cycles.

Usage constraints:
- The SS high time between frames must be at least 6 clk periods; otherwise overrun behaviour applies.
- SS pulses shorter than 2 clk periods may be missed. This is not flagged.

Reset mid-operation:
- Everything returns to the reset values.
- The in-flight command is lost.
- SS held low through reset release does not generate a frame end until its next rising edge.

Simultaneous events:
- A write to register 2 updates o_ctrl in the same cycle as o_wr_strobe.
- i_status is sampled in EXEC with no synchroniser. i_status must be clk-synchronous.

## Test plan
- Reset, then frame 0x82001234 with SS high for 10 clk -> reg2 = 0x1234, o_ctrl = 0x1234, one o_wr_strobe pulse, o_data = 0x00021234 within 6 clk of SS rising, one o_frame_done pulse.
- Read frames 0x00000000 then 0x01000000 with i_status = 0xBEEF -> o_data = 0x01005A01, then 0x0201BEEF.
- Write 0x80000001 (register 0) and read 0x09000000 (addr 9) -> err bit set, rdata = 0, register 0 still reads 0x5A01, no o_wr_strobe pulse.
- SS high for only 3 clk before the next frame's SS low -> o_data unchanged, no frame_done pulse. The next frame with long SS high sets bit 22 = 1; the frame after that has bit 22 = 0.
- 256 read frames -> frame_cnt field wraps 0xFF -> 0x00.
- rst_n asserted during EXEC of a write -> reg unchanged (0), o_data = 0. Releasing reset with SS low, then raising SS, produces exactly one frame.
